wb_rr_arbiter: RTL and testbench

//  Shares one Wishbone slave port among MASTER_COUNT Wishbone masters (e.g. several wb_master

---
 rtl/wb_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
//   Shares one Wishbone slave port among MASTER_COUNT Wishbone masters.
//   Masters are granted in round-robin order, starting after the last master
//   that was served. A grant is held for the master's whole cyc period.
//   ack is returned only to the granted master. Read data is broadcast to
//   every master. A watchdog revokes a grant whose strobe stalls without an
//   ack for TIMEOUT_CYCLES cycles. The revoked master is then locked out
//   until it drops cyc.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   m_cyc_i/stb_i/we_i   per-master control, bit i = master i
//   m_dat_i/m_adr_i      per-master write data / address, packed i*W +: W
//   m_ack_o        per-master ack, only the granted bit can be set
//   m_dat_o        slave read data broadcast to all masters
//   s_*_o          muxed request towards the slave
//   s_ack_i/s_dat_i      slave response
//   grant_o        registered one-hot grant, zero while idle
//   timeout_o      one-cycle pulse when the watchdog revokes a grant
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int MASTER_COUNT   = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [MASTER_COUNT-1:0]          m_cyc_i,
  input  logic [MASTER_COUNT-1:0]          m_stb_i,
  input  logic [MASTER_COUNT-1:0]          m_we_i,
  input  logic [MASTER_COUNT*DATA_WIDTH-1:0] m_dat_i,
  input  logic [MASTER_COUNT*ADDR_WIDTH-1:0] m_adr_i,
  output logic [MASTER_COUNT-1:0]          m_ack_o,
  output logic [DATA_WIDTH-1:0]            m_dat_o,
  output logic                             s_cyc_o,
  output logic                             s_stb_o,
  output logic                             s_we_o,
  output logic [DATA_WIDTH-1:0]            s_dat_o,
  output logic [ADDR_WIDTH-1:0]            s_adr_o,
  input  logic                             s_ack_i,
  input  logic [DATA_WIDTH-1:0]            s_dat_i,
  output logic [MASTER_COUNT-1:0]          grant_o,
  output logic                             timeout_o
);

  localparam int PW = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  // The grant is revoked on the clock edge that ends the last allowed stalled
  // cycle, so the count compared against is one below the limit.
  localparam logic [CW-1:0] WD_LAST   = WD_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [PW-1:0] PTR_RESET = PW'(MASTER_COUNT - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state_q;
  logic [MASTER_COUNT-1:0] grant_q;
  logic [MASTER_COUNT-1:0] mask_q;
  logic [PW-1:0]           grantIdx_q;
  logic [PW-1:0]           ptr_q;
  logic [CW-1:0]           wdog_q;
  logic                    timeout_q;

  logic [MASTER_COUNT-1:0] eligible;
  logic [MASTER_COUNT-1:0] grant_d;
  logic [PW-1:0]           grantIdx_d;
  logic                    grantValid_d;
  logic                    stall;

  // Rotating priority search: the first eligible master after the
  // last-served pointer, wrapping modulo MASTER_COUNT.
  always_comb begin
    logic [PW-1:0] cand;
    cand         = '0;
    eligible     = m_cyc_i & ~mask_q;
    grantValid_d = 1'b0;
    grantIdx_d   = '0;
    grant_d      = '0;
    for (int k = 1; k <= MASTER_COUNT; k++) begin
      cand = PW'((int'(ptr_q) + k) % MASTER_COUNT);
      if (!grantValid_d && eligible[cand]) begin
        grantValid_d = 1'b1;
        grantIdx_d   = cand;
      end
    end
    if (grantValid_d) begin
      grant_d[grantIdx_d] = 1'b1;
    end
  end

  // The slave-side request is a plain AND-OR mux on the registered grant.
  // An asynchronous reset therefore drops every s_* and m_ack_o output
  // at once.
  always_comb begin
    s_dat_o = '0;
    s_adr_o = '0;
    for (int i = 0; i < MASTER_COUNT; i++) begin
      s_dat_o = s_dat_o | (m_dat_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
      s_adr_o = s_adr_o | (m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_q[i]}});
    end
  end

  assign s_cyc_o   = |(m_cyc_i & grant_q);
  assign s_stb_o   = |(m_stb_i & grant_q);
  assign s_we_o    = |(m_we_i & grant_q);
  assign m_ack_o   = grant_q & {MASTER_COUNT{s_ack_i}};
  assign m_dat_o   = s_dat_i;
  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;
  assign stall     = s_stb_o & ~s_ack_i;

  // Arbiter FSM. Release has priority over the watchdog, so a master that
  // drops cyc in its last stalled cycle is released normally. A master that
  // is already masked stays masked until it drops cyc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grantIdx_q <= '0;
      ptr_q      <= PTR_RESET;
      mask_q     <= '0;
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      mask_q    <= mask_q & m_cyc_i;
      case (state_q)
        IDLE: begin
          wdog_q <= '0;
          if (grantValid_d) begin
            grant_q    <= grant_d;
            grantIdx_q <= grantIdx_d;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (!s_cyc_o) begin
            grant_q <= '0;
            ptr_q   <= grantIdx_q;
            wdog_q  <= '0;
            state_q <= IDLE;
          end else if (WD_EN && stall) begin
            if (wdog_q >= WD_LAST) begin
              timeout_q <= 1'b1;
              grant_q   <= '0;
              ptr_q     <= grantIdx_q;
              mask_q    <= (mask_q & m_cyc_i) | grant_q;
              wdog_q    <= '0;
              state_q   <= IDLE;
            end else begin
              wdog_q <= wdog_q + CW'(1);
            end
          end else if (s_ack_i) begin
            wdog_q <= '0;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_rr_arbiter
//   Directed bench for wb_rr_arbiter with two masters and an 8-cycle
//   watchdog. Inputs change 2 time units after each rising edge. Outputs are
//   sampled 1 time unit after that, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_wb_rr_arbiter;

  localparam int MC = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [MC-1:0]    m_cyc;
  logic [MC-1:0]    m_stb;
  logic [MC-1:0]    m_we;
  logic [MC*DW-1:0] m_dat;
  logic [MC*AW-1:0] m_adr;
  logic [MC-1:0]    m_ack_o;
  logic [DW-1:0]    m_dat_o;
  logic             s_cyc_o;
  logic             s_stb_o;
  logic             s_we_o;
  logic [DW-1:0]    s_dat_o;
  logic [AW-1:0]    s_adr_o;
  logic             s_ack;
  logic [DW-1:0]    s_dat;
  logic [MC-1:0]    grant_o;
  logic             timeout_o;

  int checks = 0;
  int errors = 0;

  wb_rr_arbiter #(
    .MASTER_COUNT(MC),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m_cyc_i(m_cyc),
    .m_stb_i(m_stb),
    .m_we_i(m_we),
    .m_dat_i(m_dat),
    .m_adr_i(m_adr),
    .m_ack_o(m_ack_o),
    .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o),
    .s_we_o(s_we_o),
    .s_dat_o(s_dat_o),
    .s_adr_o(s_adr_o),
    .s_ack_i(s_ack),
    .s_dat_i(s_dat),
    .grant_o(grant_o),
    .timeout_o(timeout_o)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Advance to the input-drive point of the next cycle
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive master control and slave ack, then let combinational paths settle
  task automatic applyStimulus(input logic [MC-1:0] cyc, input logic [MC-1:0] stb,
                               input logic [MC-1:0] we, input logic ack);
    m_cyc = cyc;
    m_stb = stb;
    m_we  = we;
    s_ack = ack;
    #1;
  endtask

  // One comparison: count it, and report it if it does not match
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold reset for two edges with all requests low, then release between edges
  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0, '0, '0, 1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Directed sequence
  initial begin
    logic [MC-1:0] expG;
    m_dat = '0;
    m_adr = '0;
    s_dat = '0;

    // Reset state, then one master0 write acked two cycles after the grant
    doReset();
    checkOutput("rst_grant", grant_o, 0);
    checkOutput("rst_timeout", timeout_o, 0);
    checkOutput("rst_scyc", s_cyc_o, 0);
    checkOutput("rst_mack", m_ack_o, 0);
    s_dat = 32'hCAFEF00D;
    #1;
    checkOutput("rst_mdat", m_dat_o, 32'hCAFEF00D);
    m_adr[31:0] = 32'd5;
    m_dat[31:0] = 32'h11111111;
    applyStimulus(2'b01, 2'b01, 2'b01, 1'b0);
    checkOutput("t1_latency", grant_o, 2'b00);
    step();
    checkOutput("t1_grant", grant_o, 2'b01);
    checkOutput("t1_scyc", s_cyc_o, 1);
    checkOutput("t1_sadr", s_adr_o, 32'd5);
    checkOutput("t1_sdat", s_dat_o, 32'h11111111);
    checkOutput("t1_swe", s_we_o, 1);
    checkOutput("t1_noack", m_ack_o, 2'b00);
    step();
    s_dat = 32'h12345678;
    applyStimulus(2'b01, 2'b01, 2'b01, 1'b1);
    checkOutput("t1_ack", m_ack_o, 2'b01);
    checkOutput("t1_rdat", m_dat_o, 32'h12345678);
    step();
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
    checkOutput("t1_ackdone", m_ack_o, 2'b00);
    checkOutput("t1_holdgrant", grant_o, 2'b01);
    checkOutput("t1_scycdrop", s_cyc_o, 0);
    step();
    checkOutput("t1_release", grant_o, 2'b00);

    // Simultaneous requests after reset rotate 0, gap, 1, gap, 0
    doReset();
    m_adr[63:32] = 32'd7;
    applyStimulus(2'b11, 2'b11, 2'b00, 1'b0);
    step();
    checkOutput("t2_first", grant_o, 2'b01);
    checkOutput("t2_sadr0", s_adr_o, 32'd5);
    applyStimulus(2'b11, 2'b11, 2'b00, 1'b1);
    checkOutput("t2_ack0", m_ack_o, 2'b01);
    step();
    applyStimulus(2'b10, 2'b10, 2'b00, 1'b0);
    checkOutput("t2_hold0", grant_o, 2'b01);
    step();
    checkOutput("t2_gap", grant_o, 2'b00);
    step();
    checkOutput("t2_second", grant_o, 2'b10);
    checkOutput("t2_sadr1", s_adr_o, 32'd7);
    applyStimulus(2'b10, 2'b10, 2'b00, 1'b1);
    checkOutput("t2_ack1", m_ack_o, 2'b10);
    step();
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
    checkOutput("t2_scycdrop", s_cyc_o, 0);
    step();
    checkOutput("t2_idle", grant_o, 2'b00);
    applyStimulus(2'b11, 2'b11, 2'b00, 1'b0);
    step();
    checkOutput("t2_again", grant_o, 2'b01);

    // Watchdog: master1 stalls, master0 waits, master1 stays masked
    applyStimulus(2'b10, 2'b10, 2'b00, 1'b0);
    step();
    checkOutput("t4_gap", grant_o, 2'b00);
    applyStimulus(2'b11, 2'b11, 2'b00, 1'b0);
    step();
    for (int i = 0; i < TO; i++) begin
      checkOutput("t4_stallgrant", grant_o, 2'b10);
      checkOutput("t4_stalltimeout", timeout_o, 0);
      step();
    end
    checkOutput("t4_pulse", timeout_o, 1);
    checkOutput("t4_revoked", grant_o, 2'b00);
    step();
    checkOutput("t4_pulseend", timeout_o, 0);
    checkOutput("t4_m0next", grant_o, 2'b01);
    applyStimulus(2'b10, 2'b10, 2'b00, 1'b0);
    step();
    checkOutput("t4_m0release", grant_o, 2'b00);
    step();
    checkOutput("t4_masked", grant_o, 2'b00);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
    step();
    applyStimulus(2'b10, 2'b10, 2'b00, 1'b0);
    step();
    checkOutput("t4_unmasked", grant_o, 2'b10);
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);

    // Reset in the middle of a master0 transfer
    doReset();
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b0);
    step();
    checkOutput("t5_grant", grant_o, 2'b01);
    checkOutput("t5_scyc", s_cyc_o, 1);
    rst = 1'b1;
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b1);
    checkOutput("t5_rstscyc", s_cyc_o, 0);
    checkOutput("t5_rstgrant", grant_o, 2'b00);
    checkOutput("t5_rstmack", m_ack_o, 2'b00);
    step();
    checkOutput("t5_inrst", grant_o, 2'b00);
    rst = 1'b0;
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b0);
    step();
    checkOutput("t5_regrant", grant_o, 2'b01);
    applyStimulus(2'b01, 2'b01, 2'b00, 1'b1);
    checkOutput("t5_ack", m_ack_o, 2'b01);
    step();
    applyStimulus(2'b00, 2'b00, 2'b00, 1'b0);
    step();
    checkOutput("t5_release", grant_o, 2'b00);
    applyStimulus(2'b11, 2'b11, 2'b00, 1'b0);
    step();

    // Two masters issuing back-to-back single accesses alternate grants
    for (int r = 0; r < 4; r++) begin
      expG = (r % 2 == 0) ? 2'b10 : 2'b01;
      checkOutput("t3_altgrant", grant_o, expG);
      applyStimulus(2'b11, 2'b11, 2'b00, 1'b1);
      checkOutput("t3_altack", m_ack_o, expG);
      step();
      applyStimulus(2'b11 & ~expG, 2'b11 & ~expG, 2'b00, 1'b0);
      step();
      checkOutput("t3_altgap", grant_o, 2'b00);
      applyStimulus(2'b11, 2'b11, 2'b00, 1'b0);
      step();
    end
    checkOutput("t3_notimeout", timeout_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
